matrix_multi: RTL

- Upstream producer for the pairwise adder stage: computes the 2x2 matrix product C = A x B.
- Reads operand elements from two operand register files and forms the 8 partial products a_ik*b_kj in 32-bit arithmetic.
- Pushes the products into the shared result FIFO in pair order, so the adder's pop-pop-add-write loop yields C in row-major order at wAddr 0..3.
- On the last push, raises adder_opstart and multi_opdone; multi_opclear returns both stages to idle.

---
 rtl/matrix_multi_pkg.sv | 28 ++
 rtl/matrix_multi_mul.sv | 15 +
 rtl/matrix_multi.sv | 126 ++++++++++++
 3 files changed

// File: rtl/matrix_multi_pkg.sv
// Shared constants, state encoding and operand-index helpers for the 2x2 matrix multiplier.
package matrix_multi_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_CNT_W      = 4;
    localparam int MAT_DIM        = 2;
    localparam int PROD_COUNT     = MAT_DIM * MAT_DIM * MAT_DIM;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_MUL   = 3'd2,
        ST_PUSH  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // cnt = {i, j, k}; A is read row-major as {i, k}
    function automatic logic [1:0] a_index(input logic [2:0] c);
        return {c[2], c[0]};
    endfunction

    // B is read row-major as {k, j}
    function automatic logic [1:0] b_index(input logic [2:0] c);
        return {c[0], c[1]};
    endfunction

endpackage

// File: rtl/matrix_multi_mul.sv
// Combinational DATA_W x DATA_W multiplier keeping only the low DATA_W bits.
// The low half is identical for signed and unsigned operands.
module mul32_lo
    import matrix_multi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/matrix_multi.sv
// 2x2 matrix product producer: fetches A/B elements, multiplies them and
// pushes the eight partial products into the result FIFO in pair order, so
// a pop-pop-add consumer yields C in row-major order.
module matrix_multi
    import matrix_multi_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              multi_opstart,
    input  logic              multi_opclear,
    output logic [1:0]        ra_addr,
    input  logic [DATA_W-1:0] ra_data,
    output logic [1:0]        rb_addr,
    input  logic [DATA_W-1:0] rb_data,
    input  logic [CNT_W-1:0]  fifo_data_count,
    output logic              fifo_we,
    output logic [DATA_W-1:0] fifo_din,
    output logic              adder_opstart,
    output logic              multi_opdone
);

    state_t            state;
    state_t            state_next;
    logic [2:0]        cnt;
    logic [2:0]        cnt_next;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] prod;
    logic [DATA_W-1:0] prod_lo;
    logic              fifo_full;

    mul32_lo #(
        .DATA_W(DATA_W)
    ) u_mul (
        .a(op_a),
        .b(op_b),
        .p(prod_lo)
    );

    assign fifo_full = (fifo_data_count >= CNT_W'(FIFO_DEPTH));
    assign fifo_din  = prod;

    // State and product-index register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Operands are captured in FETCH and the truncated product in MUL; prod
    // holds through PUSH stalls and keeps its value afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a <= '0;
            op_b <= '0;
            prod <= '0;
        end else begin
            if (state == ST_FETCH) begin
                op_a <= ra_data;
                op_b <= rb_data;
            end
            if (state == ST_MUL) begin
                prod <= prod_lo;
            end
        end
    end

    // Next-state and output decode; clear overrides everything but reset.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        ra_addr       = 2'b00;
        rb_addr       = 2'b00;
        fifo_we       = 1'b0;
        adder_opstart = 1'b0;
        multi_opdone  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (multi_opstart) begin
                    state_next = ST_FETCH;
                    cnt_next   = 3'd0;
                end
            end
            ST_FETCH: begin
                ra_addr    = a_index(cnt);
                rb_addr    = b_index(cnt);
                state_next = ST_MUL;
            end
            ST_MUL: begin
                state_next = ST_PUSH;
            end
            ST_PUSH: begin
                if (!fifo_full) begin
                    fifo_we = 1'b1;
                    if (cnt == 3'(PROD_COUNT - 1)) begin
                        state_next = ST_DONE;
                    end else begin
                        cnt_next   = cnt + 3'd1;
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                adder_opstart = 1'b1;
                multi_opdone  = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (multi_opclear) begin
            state_next = ST_IDLE;
            cnt_next   = 3'd0;
            fifo_we    = 1'b0;
        end
    end

endmodule
